// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: drives the instruction memory address, buffers {pc, word}
// pairs in a small FIFO and hands them to decode over valid/ready.
module instr_fetch_ctrl #(
    parameter int          DEPTH    = 2,
    parameter logic [7:0]  RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [7:0]  mem_a,
    input  logic [31:0] mem_rd,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_addr,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [7:0]  instr_pc,
    input  logic        instr_ready,
    output logic [7:0]  fetch_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [7:0]       fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [1:0]       fsm_state;
    logic             pop;
    logic             do_fetch;

    // Small distributed storage: the head must be visible in the cycle after
    // the write, so reads are asynchronous from the entry array.
    logic [7:0]  pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    // The FSM classifies the current cycle from run, occupancy and pop;
    // a FETCH cycle without a redirect is exactly a fetch.
    always_comb begin
        pop = (count_q != '0) && instr_ready;
        if (rst) begin
            fsm_state = ST_IDLE;
        end else if (redirect_valid) begin
            fsm_state = run ? ST_FETCH : ST_IDLE;
        end else if (!run) begin
            fsm_state = ST_IDLE;
        end else if ((count_q == DEPTH_C) && !pop) begin
            fsm_state = ST_FULL;
        end else begin
            fsm_state = ST_FETCH;
        end
        do_fetch = (fsm_state == ST_FETCH) && !redirect_valid;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_addr;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_fetch) begin
                wr_ptr_d   = wr_ptr_q + 1'b1;
                fetch_pc_d = fetch_pc_q + 8'd1;
            end
            if (do_fetch && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !do_fetch) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // do_fetch is already low during reset, so storage needs no reset term.
    always_ff @(posedge clk) begin
        if (do_fetch) begin
            pc_mem[wr_ptr_q]    <= fetch_pc_q;
            instr_mem[wr_ptr_q] <= mem_rd;
        end
    end

    assign mem_a       = fetch_pc_q;
    assign fetch_pc    = fetch_pc_q;
    assign instr_valid = (count_q != '0);
    assign instr_data  = instr_valid ? instr_mem[rd_ptr_q] : 32'h0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr_q] : 8'h0;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: a queue-level fetch model predicts the
// FIFO contents and fetch pointer; a negedge monitor compares the DUT to it.
module tb_instr_fetch_ctrl;

    localparam int         DEPTH    = 2;
    localparam logic [7:0] RESET_PC = 8'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [7:0]  mem_a;
    logic [31:0] mem_rd;
    logic        redirect_valid;
    logic [7:0]  redirect_addr;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [7:0]  instr_pc;
    logic        instr_ready;
    logic [7:0]  fetch_pc;

    instr_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .mem_a(mem_a),
        .mem_rd(mem_rd),
        .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr),
        .instr_valid(instr_valid),
        .instr_data(instr_data),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .fetch_pc(fetch_pc)
    );

    always #5 clk = ~clk;

    // Instruction memory: word i holds A000_0000 + i.
    assign mem_rd = 32'hA000_0000 + {24'h0, mem_a};

    int         n_cmp = 0;
    int         n_err = 0;
    bit         mon_en = 1'b0;
    logic [7:0] exp_fifo[$];
    logic [7:0] m_pc = RESET_PC;

    // Reference model: queue of expected pcs plus the fetch pointer.
    always @(posedge clk) begin : model
        int sz;
        bit mpop;
        sz = exp_fifo.size();
        if (rst) begin
            exp_fifo.delete();
            m_pc = RESET_PC;
        end else begin
            mpop = (sz > 0) && instr_ready;
            if (mpop) void'(exp_fifo.pop_front());
            if (redirect_valid) begin
                exp_fifo.delete();
                m_pc = redirect_addr;
            end else if (run && (sz < DEPTH || mpop)) begin
                exp_fifo.push_back(m_pc);
                m_pc = m_pc + 8'd1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [7:0] head;
        if (mon_en) begin
            chk("mem_a", {24'h0, mem_a}, {24'h0, m_pc});
            chk("fetch_pc", {24'h0, fetch_pc}, {24'h0, m_pc});
            chk("instr_valid", {31'h0, instr_valid}, {31'h0, exp_fifo.size() != 0});
            if (exp_fifo.size() != 0) begin
                head = exp_fifo[0];
                chk("instr_pc", {24'h0, instr_pc}, {24'h0, head});
                chk("instr_data", instr_data, 32'hA000_0000 + {24'h0, head});
                if (instr_ready)
                    $display("accept pc=%h data=%h", instr_pc, instr_data);
            end else begin
                chk("instr_pc_idle", {24'h0, instr_pc}, 32'h0);
                chk("instr_data_idle", instr_data, 32'h0);
            end
        end
    end

    task automatic step(input bit r, input bit rn, input bit rdy, input bit rv,
                        input logic [7:0] ra, input int n);
        rst            = r;
        run            = rn;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_addr  = ra;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_addr = 8'h00;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        // streaming from reset
        step(0, 1, 1, 0, 8'h00, 6);
        // restart, stall to full, then drain
        step(1, 0, 0, 0, 8'h00, 1);
        step(0, 1, 0, 0, 8'h00, 5);
        step(0, 1, 1, 0, 8'h00, 4);
        // redirect with a pop in the same cycle
        step(0, 1, 0, 0, 8'h00, 2);
        step(0, 1, 1, 1, 8'h40, 1);
        step(0, 1, 1, 0, 8'h00, 4);
        // wrap past FF
        step(0, 1, 1, 1, 8'hFE, 1);
        step(0, 1, 1, 0, 8'h00, 5);
        // run dropped with a full queue, drain, resume
        step(0, 1, 0, 0, 8'h00, 3);
        step(0, 0, 1, 0, 8'h00, 4);
        step(0, 1, 1, 0, 8'h00, 3);
        // reset overriding a redirect
        step(1, 1, 1, 1, 8'h80, 1);
        step(0, 1, 1, 0, 8'h00, 3);
        // back-to-back redirects, last wins
        step(0, 1, 1, 1, 8'h10, 1);
        step(0, 1, 1, 1, 8'h20, 1);
        step(0, 1, 1, 0, 8'h00, 3);
        // redirect while run is low
        step(0, 0, 1, 1, 8'h55, 1);
        step(0, 0, 1, 0, 8'h00, 2);
        step(0, 1, 1, 0, 8'h00, 3);
        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 80,
                 $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 10,
                 ($urandom_range(0, 3) == 0) ? 8'hFD + 8'($urandom_range(0, 2))
                                             : 8'($urandom_range(0, 255)),
                 1);
        end
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
